// File: rtl/wisc_pkg.sv
// Shared ISA constants for the shift datapath.
// Holds the shift-class opcodes and the shifter mode encodings, plus a
// small decode helper. The shifter, the decoder and the issue stage all
// import this package.
package wisc_pkg;

   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRA = 2'b01;
   localparam logic [1:0] MODE_ROR = 2'b10;

   typedef struct packed {
      logic       sel;
      logic [1:0] mode;
   } shift_dec_t;

   // Non-shift opcodes decode to sel = 0 with MODE_SLL, so the shifter
   // never sees mode 2'b11.
   function automatic shift_dec_t decode_shift(input logic [3:0] opcode);
      shift_dec_t d;
      d.sel  = 1'b0;
      d.mode = MODE_SLL;
      case (opcode)
         OP_SLL: begin d.sel = 1'b1; d.mode = MODE_SLL; end
         OP_SRA: begin d.sel = 1'b1; d.mode = MODE_SRA; end
         OP_ROR: begin d.sel = 1'b1; d.mode = MODE_ROR; end
         default: begin d.sel = 1'b0; d.mode = MODE_SLL; end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/shift_fwd_mux.sv
// Combinational 3-source operand forwarding mux.
// Ports:
//   rs_i         source register index of the consumer
//   rs_data_i    register-file value captured for rs
//   exmem_we_i / exmem_rd_i / exmem_data_i   youngest producer
//   memwb_we_i / memwb_rd_i / memwb_data_i   older producer
//   operand_o    resolved operand
// r0 is hardwired zero and is never forwarded. EX/MEM beats MEM/WB
// because it holds the younger write to the same register.
module shift_fwd_mux (
   input  logic [3:0]  rs_i,
   input  logic [15:0] rs_data_i,
   input  logic        exmem_we_i,
   input  logic [3:0]  exmem_rd_i,
   input  logic [15:0] exmem_data_i,
   input  logic        memwb_we_i,
   input  logic [3:0]  memwb_rd_i,
   input  logic [15:0] memwb_data_i,
   output logic [15:0] operand_o
);

   always_comb begin
      operand_o = rs_data_i;
      if (rs_i == 4'd0) begin
         operand_o = 16'h0000;
      end else if (exmem_we_i && (exmem_rd_i == rs_i)) begin
         operand_o = exmem_data_i;
      end else if (memwb_we_i && (memwb_rd_i == rs_i)) begin
         operand_o = memwb_data_i;
      end
   end

endmodule

// File: rtl/shift_issue_stage.sv
// ID/EX pipeline stage for shift-class instructions (SLL, SRA, ROR).
// Decodes the ID instruction into shifter operand/amount/mode, registers
// it with stall and flush control, and forwards the rs operand from
// EX/MEM and MEM/WB.
// Ports:
//   clk, rst_n (sync, active low), stall, flush
//   id_valid, id_instr[15:0] {op, rd, rs, imm}, id_rs_data[15:0]
//   exmem_we/rd/data, memwb_we/rd/data   forwarding sources
//   ex_valid, ex_shift_sel, ex_shift_in[15:0], ex_shift_val[3:0],
//   ex_mode[1:0], ex_rd[3:0], ex_we       stage outputs to EX
module shift_issue_stage
   import wisc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        id_valid,
   input  logic [15:0] id_instr,
   input  logic [15:0] id_rs_data,
   input  logic        exmem_we,
   input  logic [3:0]  exmem_rd,
   input  logic [15:0] exmem_data,
   input  logic        memwb_we,
   input  logic [3:0]  memwb_rd,
   input  logic [15:0] memwb_data,
   output logic        ex_valid,
   output logic        ex_shift_sel,
   output logic [15:0] ex_shift_in,
   output logic [3:0]  ex_shift_val,
   output logic [1:0]  ex_mode,
   output logic [3:0]  ex_rd,
   output logic        ex_we
);

   logic        valid_q,     valid_d;
   logic        shift_sel_q, shift_sel_d;
   logic [1:0]  mode_q,      mode_d;
   logic [3:0]  imm_q,       imm_d;
   logic [3:0]  rd_q,        rd_d;
   logic [3:0]  rs_q,        rs_d;
   logic        we_q,        we_d;
   logic [15:0] rs_data_q,   rs_data_d;

   shift_dec_t  id_dec;
   logic        id_is_shift;

   assign id_dec      = decode_shift(id_instr[15:12]);
   // An invalid ID slot must never look like a shift or a write.
   assign id_is_shift = id_valid && id_dec.sel;

   always_comb begin
      valid_d     = valid_q;
      shift_sel_d = shift_sel_q;
      mode_d      = mode_q;
      imm_d       = imm_q;
      rd_d        = rd_q;
      rs_d        = rs_q;
      we_d        = we_q;
      rs_data_d   = rs_data_q;
      if (flush) begin
         valid_d     = 1'b0;
         shift_sel_d = 1'b0;
         mode_d      = MODE_SLL;
         imm_d       = 4'd0;
         rd_d        = 4'd0;
         rs_d        = 4'd0;
         we_d        = 1'b0;
         rs_data_d   = 16'h0000;
      end else if (!stall) begin
         valid_d     = id_valid;
         shift_sel_d = id_is_shift;
         mode_d      = id_is_shift ? id_dec.mode : MODE_SLL;
         imm_d       = id_instr[3:0];
         rd_d        = id_instr[11:8];
         rs_d        = id_instr[7:4];
         we_d        = id_is_shift && (id_instr[11:8] != 4'd0);
         rs_data_d   = id_rs_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         shift_sel_q <= 1'b0;
         mode_q      <= MODE_SLL;
         imm_q       <= 4'd0;
         rd_q        <= 4'd0;
         rs_q        <= 4'd0;
         we_q        <= 1'b0;
         rs_data_q   <= 16'h0000;
      end else begin
         valid_q     <= valid_d;
         shift_sel_q <= shift_sel_d;
         mode_q      <= mode_d;
         imm_q       <= imm_d;
         rd_q        <= rd_d;
         rs_q        <= rs_d;
         we_q        <= we_d;
         rs_data_q   <= rs_data_d;
      end
   end

   // Forwarding runs on the registered rs every cycle, so a stalled
   // instruction picks up a producer that advances during the stall.
   shift_fwd_mux u_fwd (
      .rs_i         (rs_q),
      .rs_data_i    (rs_data_q),
      .exmem_we_i   (exmem_we),
      .exmem_rd_i   (exmem_rd),
      .exmem_data_i (exmem_data),
      .memwb_we_i   (memwb_we),
      .memwb_rd_i   (memwb_rd),
      .memwb_data_i (memwb_data),
      .operand_o    (ex_shift_in)
   );

   assign ex_valid     = valid_q;
   assign ex_shift_sel = shift_sel_q;
   assign ex_shift_val = imm_q;
   assign ex_mode      = mode_q;
   assign ex_rd        = rd_q;
   assign ex_we        = we_q;

endmodule
